// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM arbiter slice.
//   - Default ROM geometry (word-address width, instruction width)
//   - FSM state encoding for the access sequencer
//   - Requester ID constants stored with each granted access
package rom_arb_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic REQ_ID_FETCH = 1'b0;
  localparam logic REQ_ID_DEBUG = 1'b1;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational grant selection between the fetch and debug requesters.
// Optional feature macro: ROM_ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests go to the requester not served last
//   undefined : fetch always wins simultaneous requests
// Ports:
//   en_i        - arbiter is able to accept an access this cycle
//   f_req_i     - fetch request
//   d_req_i     - debug request
//   last_dbg_i  - (round-robin build only) debug was the last served
//   f_gnt_o     - fetch granted
//   d_gnt_o     - debug granted
module rom_arb_pick (
  input  logic en_i,
  input  logic f_req_i,
  input  logic d_req_i,
`ifdef ROM_ARB_ROUND_ROBIN_EN
  input  logic last_dbg_i,
`endif
  output logic f_gnt_o,
  output logic d_gnt_o
);

  // Grant selection; at most one grant is ever raised.
  always_comb begin
    f_gnt_o = 1'b0;
    d_gnt_o = 1'b0;
    if (!en_i) begin
      f_gnt_o = 1'b0;
      d_gnt_o = 1'b0;
    end else if (f_req_i && d_req_i) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
      if (last_dbg_i) begin
        f_gnt_o = 1'b1;
      end else begin
        d_gnt_o = 1'b1;
      end
`else
      f_gnt_o = 1'b1;
`endif
    end else begin
      f_gnt_o = f_req_i;
      d_gnt_o = d_req_i;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single combinational instruction ROM.
// A fetch port (byte PC) and a debug port (word address) share the ROM;
// each access takes two cycles from grant to response strobe.
// Optional feature macro: ROM_ARB_ROUND_ROBIN_EN (round-robin instead of
// fetch-first priority on simultaneous requests).
// Ports:
//   clk, rstn                  - clock, async active-low reset
//   f_req/f_addr/f_gnt         - fetch request, byte address, grant
//   f_valid/f_err/f_data       - fetch response strobe, error flag, word
//   d_req/d_addr/d_gnt         - debug request, word address, grant
//   d_valid/d_data             - debug response strobe, word
//   rom_addr/rom_data          - word address to ROM, ROM read data
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              f_req,
  input  logic [63:0]       f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic              f_err,
  output logic [DATA_W-1:0] f_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  arb_state_e        state_q;
  logic              id_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic              f_valid_q;
  logic              f_err_q;
  logic [DATA_W-1:0] f_data_q;
  logic              d_valid_q;
  logic [DATA_W-1:0] d_data_q;

  logic              grant_en;
  logic              gnt_any;
  logic              req_id_d;
  logic [ADDR_W-1:0] req_addr_d;
  logic              req_err_d;
  logic              f_misalign;
  logic              f_out_of_range;

  // Only IDLE and RESP may accept; RESP accepting gives 2-cycle throughput.
  assign grant_en = (state_q == IDLE) || (state_q == RESP);

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic last_dbg_q;

  // Remember who was served last so a tie goes to the other requester.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_dbg_q <= 1'b0;
    end else if (gnt_any) begin
      last_dbg_q <= d_gnt;
    end else begin
      last_dbg_q <= last_dbg_q;
    end
  end
`endif

  rom_arb_pick u_pick (
    .en_i       (grant_en),
    .f_req_i    (f_req),
    .d_req_i    (d_req),
`ifdef ROM_ARB_ROUND_ROBIN_EN
    .last_dbg_i (last_dbg_q),
`endif
    .f_gnt_o    (f_gnt),
    .d_gnt_o    (d_gnt)
  );

  assign gnt_any = f_gnt | d_gnt;

  // A fetch outside the ROM or not word aligned is still accepted but
  // answered with an error and a zero word.
  assign f_misalign     = |f_addr[1:0];
  assign f_out_of_range = |f_addr[63:ADDR_W+2];

  assign req_id_d   = d_gnt ? REQ_ID_DEBUG : REQ_ID_FETCH;
  assign req_addr_d = d_gnt ? d_addr : f_addr[ADDR_W+1:2];
  assign req_err_d  = f_gnt & (f_misalign | f_out_of_range);

  // Access sequencer: latch request on grant, sample ROM in READ,
  // strobe the response during RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      id_q      <= REQ_ID_FETCH;
      err_q     <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
      f_data_q  <= {DATA_W{1'b0}};
      d_valid_q <= 1'b0;
      d_data_q  <= {DATA_W{1'b0}};
    end else begin
      // Strobes are single-cycle; data registers hold between strobes.
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
      d_valid_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (gnt_any) begin
            state_q <= READ;
            id_q    <= req_id_d;
            err_q   <= req_err_d;
            addr_q  <= req_addr_d;
          end else begin
            state_q <= IDLE;
          end
        end
        READ: begin
          state_q <= RESP;
          if (id_q == REQ_ID_FETCH) begin
            f_valid_q <= 1'b1;
            f_err_q   <= err_q;
            f_data_q  <= err_q ? {DATA_W{1'b0}} : rom_data;
          end else begin
            d_valid_q <= 1'b1;
            d_data_q  <= rom_data;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rom_addr = addr_q;
  assign f_valid  = f_valid_q;
  assign f_err    = f_err_q;
  assign f_data   = f_data_q;
  assign d_valid  = d_valid_q;
  assign d_data   = d_data_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: table of single accesses, then
// hand-written sequences for simultaneous requests, continuous debug
// reads and reset during an access. Responses are checked against a
// scoreboard queue filled at grant time.
module tb_rom_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          f_req;
  logic [63:0]   f_addr;
  logic          f_gnt;
  logic          f_valid;
  logic          f_err;
  logic [DW-1:0] f_data;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_data;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic          dbg;
    logic [DW-1:0] data;
    logic          err;
    int            gcyc;
  } exp_t;

  typedef struct {
    logic        dbg;
    logic [63:0] addr;
    logic        err;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[10];

  rom_arbiter dut (
    .clk      (clk),
    .rstn     (rstn),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_valid  (f_valid),
    .f_err    (f_err),
    .f_data   (f_data),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_valid  (d_valid),
    .d_data   (d_data),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: distinct, nonzero word per address.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a, 5'h15, ~a[7:0], a[7:0]};
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (f_valid || d_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_valid: got f_valid=%0b d_valid=%0b expected none (cycle %0d)",
                 f_valid, d_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("resp_port", {f_valid, d_valid}, mon_e.dbg ? 2'b01 : 2'b10);
        check("resp_data", mon_e.dbg ? d_data : f_data, mon_e.data);
        check("resp_err", f_err, mon_e.err);
        check("resp_latency", cyc - mon_e.gcyc, 2);
      end
    end else if (f_err) begin
      n_vec++;
      n_mis++;
      $display("FAIL stray_err: got f_err=1 expected 0 without f_valid (cycle %0d)", cyc);
    end
  end

  task automatic issue(input logic dbg, input logic [63:0] a, input logic exp_err, output int gcyc);
    logic          g;
    logic [AW-1:0] wa;
    exp_t          e;
    g  = 1'b0;
    wa = dbg ? a[AW-1:0] : a[AW+1:2];
    @(negedge clk);
    if (dbg) begin
      d_req  = 1'b1;
      d_addr = a[AW-1:0];
    end else begin
      f_req  = 1'b1;
      f_addr = a;
    end
    for (int k = 0; k < 8 && !g; k++) begin
      #1;
      if (dbg ? d_gnt : f_gnt) g = 1'b1;
      else @(negedge clk);
    end
    check("grant", g, 1'b1);
    gcyc = cyc;
    if (g) begin
      check("gnt_other", dbg ? f_gnt : d_gnt, 1'b0);
      e.dbg  = dbg;
      e.data = exp_err ? '0 : rom_word(wa);
      e.err  = exp_err;
      e.gcyc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check("rom_addr", rom_addr, wa);
    end
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   gc;
    int   prev;
    logic got;
    logic exp_d;
    exp_t e;

    vt[0] = '{1'b0, 64'h10,                  1'b0};
    vt[1] = '{1'b0, 64'h2002,                1'b1};
    vt[2] = '{1'b0, 64'h2000,                1'b1};
    vt[3] = '{1'b1, 64'd2047,                1'b0};
    vt[4] = '{1'b0, 64'h1FFC,                1'b0};
    vt[5] = '{1'b1, 64'd0,                   1'b0};
    vt[6] = '{1'b0, 64'h3,                   1'b1};
    vt[7] = '{1'b0, 64'h8000_0000_0000_0000, 1'b1};
    vt[8] = '{1'b0, 64'h4,                   1'b0};
    vt[9] = '{1'b1, 64'h123,                 1'b0};

    f_req  = 1'b0;
    d_req  = 1'b0;
    f_addr = 64'h0;
    d_addr = 11'h0;
    rstn   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_f_valid", f_valid, 1'b0);
    check("rst_d_valid", d_valid, 1'b0);
    check("rst_f_err", f_err, 1'b0);
    check("rst_f_data", f_data, 32'h0);
    check("rst_d_data", d_data, 32'h0);
    check("rst_rom_addr", rom_addr, 11'h0);
    rstn = 1'b1;

    // Table of single accesses, issued back to back.
    for (int i = 0; i < 10; i++) begin
      issue(vt[i].dbg, vt[i].addr, vt[i].err, gc);
    end
    drain();

    // Make debug the last served, then hold both requests for 4 accesses.
    issue(1'b1, 64'd5, 1'b0, gc);
    drain();
    f_req  = 1'b1;
    f_addr = 64'h40;
    d_req  = 1'b1;
    d_addr = 11'd9;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        #1;
        if (f_gnt || d_gnt) got = 1'b1;
        else @(negedge clk);
      end
      check("simul_grant", got, 1'b1);
`ifdef ROM_ARB_ROUND_ROBIN_EN
      exp_d = (g % 2 == 1);
`else
      exp_d = 1'b0;
`endif
      check("simul_winner", {f_gnt, d_gnt}, exp_d ? 2'b01 : 2'b10);
      e.dbg  = exp_d;
      e.data = rom_word(exp_d ? 11'd9 : 11'd16);
      e.err  = 1'b0;
      e.gcyc = cyc;
      sb.push_back(e);
      @(negedge clk);
    end
    f_req = 1'b0;
    d_req = 1'b0;
    drain();

    // Continuous debug reads of the top word: one grant every 2 cycles.
    prev = 0;
    for (int j = 0; j < 5; j++) begin
      issue(1'b1, 64'd2047, 1'b0, gc);
      if (j > 0) check("d_throughput", gc - prev, 2);
      prev = gc;
    end
    drain();

    // Reset asserted while an access is in READ: it must vanish.
    @(negedge clk);
    f_req  = 1'b1;
    f_addr = 64'h20;
    #1;
    check("rst_seq_gnt", f_gnt, 1'b1);
    @(posedge clk);
    #1;
    f_req = 1'b0;
    rstn  = 1'b0;
    #1;
    check("midrst_f_valid", f_valid, 1'b0);
    check("midrst_d_valid", d_valid, 1'b0);
    check("midrst_f_err", f_err, 1'b0);
    check("midrst_f_data", f_data, 32'h0);
    check("midrst_d_data", d_data, 32'h0);
    check("midrst_rom_addr", rom_addr, 11'h0);
    check("midrst_gnt", {f_gnt, d_gnt}, 2'b00);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    issue(1'b0, 64'h20, 1'b0, gc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, ROM word-address width (2048 words).
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port f_req, input, 1, fetch read request.
REQ-007 SHALL have port f_addr, input, 64, fetch byte address (PC).
REQ-008 SHALL have port f_gnt, output, 1, fetch request accepted this cycle.
REQ-009 SHALL have port f_valid, output, 1, fetch response strobe.
REQ-010 SHALL have port f_err, output, 1, fetch response is an error (valid with f_valid).
REQ-011 SHALL have port f_data, output, DATA_W, fetch response word.
REQ-012 SHALL have port d_req, input, 1, debug read request.
REQ-013 SHALL have port d_addr, input, ADDR_W, debug word address.
REQ-014 SHALL have port d_gnt, output, 1, debug request accepted this cycle.
REQ-015 SHALL have port d_valid, output, 1, debug response strobe.
REQ-016 SHALL have port d_data, output, DATA_W, debug response word.
REQ-017 SHALL have port rom_addr, output, ADDR_W, word address to combinational ROM.
REQ-018 SHALL have port rom_data, input, DATA_W, ROM read data (combinational from rom_addr).

Function
REQ-019 SHALL implement FSM states IDLE, READ, RESP; IDLE->READ on any grant; READ->RESP unconditionally; RESP->READ if a grant occurs in RESP, else RESP->IDLE.
REQ-020 Grants SHALL be combinational, issued only in IDLE or RESP, at most one of f_gnt/d_gnt per cycle.
REQ-021 On grant, the requester ID and word address SHALL be registered; rom_addr SHALL drive the registered address.
REQ-022 In READ, rom_data SHALL be captured into the response register; in RESP, exactly one of f_valid/d_valid SHALL pulse high for one cycle with the captured data.
REQ-023 Latency grant-to-valid SHALL be exactly 2 cycles; back-to-back throughput SHALL be one access per 2 cycles.
REQ-024 Fetch word address SHALL be f_addr[ADDR_W+1:2].
REQ-025 A fetch with f_addr[1:0] != 0 or any of f_addr[63:ADDR_W+2] set SHALL still be granted and SHALL respond with f_err=1 and f_data=0.
REQ-026 Requesters SHALL hold req and addr stable until gnt; the block SHALL NOT buffer more than one outstanding access.
REQ-027 When idle, rom_addr SHALL hold its last value; f_data/d_data SHALL hold their last value between strobes.

Reset
REQ-028 On rstn low: state=IDLE, all gnt/valid/err=0, rom_addr=0, f_data=d_data=0, priority pointer = fetch-last-served; an in-flight access SHALL be dropped with no response.

Configuration
REQ-029 With ROM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL grant the requester not served last; single requests always granted.
REQ-030 Without ROM_ARB_ROUND_ROBIN_EN, fetch SHALL always win simultaneous requests (fixed priority) and the pointer register SHALL NOT exist.

Structure
REQ-031 ADDR_W/DATA_W defaults, FSM state encoding and requester-ID constants SHALL live in shared package rom_arb_pkg.
REQ-032 Grant logic SHALL be a sub-module rom_arb_pick; the ROM itself SHALL remain outside this block.

Verification
REQ-033 f_req, f_addr=0x10 -> f_gnt same cycle, rom_addr=4 next cycle, f_valid with f_data=rom[4] two cycles after grant.
REQ-034 f_addr=0x2002 -> f_valid with f_err=1, f_data=0; f_addr=0x2000 -> f_err=1 (out of range).
REQ-035 f_req and d_req held together 4 accesses: round-robin build -> grants F,D,F,D; fixed build -> F,F,F,F.
REQ-036 Continuous d_req, d_addr=2047 -> d_valid every 2 cycles, d_data=rom[2047].
REQ-037 rstn low during READ -> no valid pulse, all outputs 0; after release, new request served with normal 2-cycle latency.
